// File: rtl/button_pkg.sv
// Shared types and default timing for the button event FSM.
// Timing defaults assume a 65 MHz clock with a 10 ms tick.
package button_pkg;

  // FSM states with fixed encodings.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } state_t;

  // 0.01 s at 65 MHz.
  localparam int unsigned DEF_TICK_DIV     = 650000;
  // 0.5 s before long_press.
  localparam int unsigned DEF_LONG_TICKS   = 50;
  // 0.1 s between auto-repeat pulses.
  localparam int unsigned DEF_REPEAT_TICKS = 10;

  // Larger of two tick limits; sizes the shared hold counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing one tick every TICK_DIV enabled cycles.
// clear has priority over enable and forces the count back to 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 650000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0] count;

  // Tick marks the last cycle of each TICK_DIV period.
  assign tick = enable && (count == PW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 while enabled, wrapping on tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tick) count <= '0;
      else      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/button_press_fsm.sv
// Turns the debounced button level into press / release / long-press /
// auto-repeat event pulses plus a held level.
// Optional macro BUTTON_AUTOREPEAT_EN enables repeat_pulse generation in HELD;
// without it repeat_pulse is tied low and HELD only waits for release.
module button_press_fsm
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clean,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_TICKS, REPEAT_TICKS) + 1);

  state_t           state;
  logic             clean_q;
  logic [CNT_W-1:0] tick_cnt;
  logic             rise;
  logic             fall;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  // Edge detection against the one-cycle delayed level.
  assign rise = clean & ~clean_q;
  assign fall = ~clean & clean_q;

  // Prescaler is frozen in IDLE so each hold is timed from its own press.
`ifdef BUTTON_AUTOREPEAT_EN
  assign pre_en  = (state == PRESSED) || (state == HELD);
`else
  assign pre_en  = (state == PRESSED);
`endif
  assign pre_clr = (state == IDLE) || fall;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (pre_en),
    .clear   (pre_clr),
    .tick    (tick)
  );

  // Event FSM with registered pulse outputs; release beats a coincident tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      clean_q       <= 1'b0;
      tick_cnt      <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      clean_q       <= clean;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          held     <= 1'b0;
          tick_cnt <= '0;
          if (rise) begin
            state <= PRESSED;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end

        PRESSED: begin
          held <= 1'b1;
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            tick_cnt      <= '0;
          end else if (tick) begin
            if (tick_cnt == CNT_W'(LONG_TICKS - 1)) begin
              state      <= HELD;
              long_press <= 1'b1;
              tick_cnt   <= '0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        HELD: begin
          held <= 1'b1;
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            tick_cnt      <= '0;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (tick) begin
            if (tick_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
              repeat_pulse <= 1'b1;
              tick_cnt     <= '0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
`endif
        end

        default: begin
          state    <= IDLE;
          held     <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_fsm.sv
// Randomized and directed bench for button_press_fsm with a cycle-count
// reference model (edges since press decide every expected pulse).
module tb_button_press_fsm;

  localparam int unsigned TD        = 4;
  localparam int unsigned LT        = 3;
  localparam int unsigned RT        = 2;
  localparam int unsigned LONG_AT   = TD * LT;
  localparam int unsigned REP_EVERY = TD * RT;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic clean   = 1'b0;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: whether a hold is active and how many edges since press.
  bit          m_active;
  bit          m_prev;
  int unsigned m_k;
  logic        e_press, e_rel, e_long, e_rep, e_held;

  button_press_fsm #(
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clean         (clean),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".press"},      press,         e_press);
    check_eq({ctx, ".release"},    release_pulse, e_rel);
    check_eq({ctx, ".long_press"}, long_press,    e_long);
    check_eq({ctx, ".repeat"},     repeat_pulse,  e_rep);
    check_eq({ctx, ".held"},       held,          e_held);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_prev   = 1'b0;
    m_k      = 0;
    e_press  = 1'b0;
    e_rel    = 1'b0;
    e_long   = 1'b0;
    e_rep    = 1'b0;
    e_held   = 1'b0;
  endtask

  // Expected outputs after a rising edge that samples level c.
  task automatic model_edge(input logic c);
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (!m_active) begin
      e_held = 1'b0;
      if (c && !m_prev) begin
        m_active = 1'b1;
        m_k      = 0;
        e_press  = 1'b1;
        e_held   = 1'b1;
      end
    end else begin
      m_k++;
      e_held = 1'b1;
      if (!c && m_prev) begin
        e_rel    = 1'b1;
        m_active = 1'b0;
      end else begin
        if (m_k == LONG_AT) e_long = 1'b1;
        if (AR && m_k > LONG_AT && ((m_k - LONG_AT) % REP_EVERY) == 0) e_rep = 1'b1;
      end
    end
    m_prev = c;
  endtask

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic step(input logic c, input string ctx);
    @(negedge clock);
    clean = c;
    @(posedge clock);
    model_edge(c);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    repeat (2) @(negedge clock);
    check_outputs("reset_hold");

    // Deassert reset on a falling edge, then idle to cycle 10.
    reset_n = 1'b1;
    repeat (9) step(1'b0, "idle");

    // Long hold: long_press at +12, repeats at +20/+28/+36 when enabled.
    step(1'b1, "rise");
    repeat (40) step(1'b1, "long_hold");
    repeat (4) step(1'b0, "after_long");

    // Short press released 5 cycles after press.
    step(1'b1, "short_rise");
    repeat (4) step(1'b1, "short_hold");
    repeat (4) step(1'b0, "short_rel");

    // Fall coinciding with the third tick: release wins over long_press.
    step(1'b1, "race_rise");
    repeat (11) step(1'b1, "race_hold");
    step(1'b0, "race_fall");
    repeat (3) step(1'b0, "race_idle");

    // Asynchronous reset in the middle of HELD with the button still down.
    step(1'b1, "rst_rise");
    repeat (20) step(1'b1, "rst_hold");
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clock);
    check_outputs("async_rst_low");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    model_edge(1'b1);
    #1;
    check_outputs("rst_repress");
    repeat (5) step(1'b1, "rst_rehold");
    repeat (3) step(1'b0, "rst_rel");

    // Randomized holds and gaps, including single-cycle blips.
    for (int i = 0; i < 40; i++) begin
      int unsigned hold_len;
      int unsigned gap_len;
      hold_len = $urandom_range(1, 45);
      gap_len  = $urandom_range(1, 6);
      repeat (hold_len) step(1'b1, "rand_hold");
      repeat (gap_len)  step(1'b0, "rand_gap");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
